// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I core.
// Takes the ID/EX register outputs, resolves operand forwarding from EX/MEM
// and MEM/WB, runs the ALU, resolves branches (combinational redirect) and
// holds the EX/MEM pipeline register.
module ex_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] pc,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm_i,
    input  logic [31:0] imm_s,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [1:0]  aluOp,
    input  logic        branch,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        regWrite,
    input  logic        aluSrc,

    input  logic [4:0]  memwb_rd,
    input  logic        memwb_regWrite,
    input  logic [31:0] memwb_value,

    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        flush,

    output logic [31:0] exmem_alu_result,
    output logic [31:0] exmem_store_data,
    output logic [4:0]  exmem_rd,
    output logic [2:0]  exmem_funct3,
    output logic        exmem_memRead,
    output logic        exmem_memWrite,
    output logic        exmem_regWrite
);

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_PASS_B = 2'b11
    } alu_op_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    alu_op_e     op_sel;
    logic        exmem_can_fwd;
    logic        ex_hit_a;
    logic        ex_hit_b;
    logic        wb_hit_a;
    logic        wb_hit_b;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] alu_out;
    logic [4:0]  shamt;
    logic [31:0] imm_b;
    logic        cond;
    logic        unused_bits;

    assign op_sel = alu_op_e'(aluOp);

    // A load in EX/MEM has no data yet, so it is never a forwarding source;
    // the decode stage inserts a bubble for load-use instead.
    assign exmem_can_fwd = FWD_EN && exmem_regWrite && !exmem_memRead;

    assign ex_hit_a = exmem_can_fwd && (rs1 != 5'd0) && (exmem_rd == rs1);
    assign ex_hit_b = exmem_can_fwd && (rs2 != 5'd0) && (exmem_rd == rs2);
    assign wb_hit_a = FWD_EN && memwb_regWrite && (rs1 != 5'd0) && (memwb_rd == rs1);
    assign wb_hit_b = FWD_EN && memwb_regWrite && (rs2 != 5'd0) && (memwb_rd == rs2);

    // Operand A selection: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a = rs1_val;
        if (ex_hit_a) begin
            fwd_a = exmem_alu_result;
        end else if (wb_hit_a) begin
            fwd_a = memwb_value;
        end
    end

    // rs2 selection, shared by the ALU, the branch comparator and store data.
    always_comb begin
        fwd_b = rs2_val;
        if (ex_hit_b) begin
            fwd_b = exmem_alu_result;
        end else if (wb_hit_b) begin
            fwd_b = memwb_value;
        end
    end

    assign op_b  = aluSrc ? imm_i : fwd_b;
    assign shamt = op_b[4:0];

    // ALU: aluOp picks fixed add/sub/pass, or a funct3/funct7 decode for
    // R/I-type arithmetic. SUB only exists in R-type, hence the aluSrc gate.
    always_comb begin
        alu_out = 32'd0;
        case (op_sel)
            ALU_ADD:    alu_out = fwd_a + op_b;
            ALU_SUB:    alu_out = fwd_a - op_b;
            ALU_PASS_B: alu_out = op_b;
            ALU_FUNCT: begin
                case (funct3)
                    F3_ADD:  alu_out = (funct7[5] && !aluSrc) ? (fwd_a - op_b) : (fwd_a + op_b);
                    F3_SLL:  alu_out = fwd_a << shamt;
                    F3_SLT:  alu_out = {31'd0, $signed(fwd_a) < $signed(op_b)};
                    F3_SLTU: alu_out = {31'd0, fwd_a < op_b};
                    F3_XOR:  alu_out = fwd_a ^ op_b;
                    F3_SR:   alu_out = funct7[5] ? $unsigned($signed(fwd_a) >>> shamt)
                                                 : (fwd_a >> shamt);
                    F3_OR:   alu_out = fwd_a | op_b;
                    F3_AND:  alu_out = fwd_a & op_b;
                    default: alu_out = 32'd0;
                endcase
            end
            default: alu_out = 32'd0;
        endcase
    end

    // The branch offset arrives in S-type layout and is reshuffled to B-type.
    assign imm_b = {{19{imm_s[31]}}, imm_s[31], imm_s[0], imm_s[10:5], imm_s[4:1], 1'b0};
    assign branch_target = pc + imm_b;

    // Branch condition always compares the two register operands.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (fwd_a == fwd_b);
            F3_BNE:  cond = (fwd_a != fwd_b);
            F3_BLT:  cond = ($signed(fwd_a) <  $signed(fwd_b));
            F3_BGE:  cond = ($signed(fwd_a) >= $signed(fwd_b));
            F3_BLTU: cond = (fwd_a <  fwd_b);
            F3_BGEU: cond = (fwd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken = branch && cond;
    assign flush        = branch_taken;

    assign unused_bits = ^{funct7[6], funct7[4:0], imm_s[30:11]};

    // EX/MEM pipeline register; no enable, bubbles flow through as zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_alu_result <= 32'd0;
            exmem_store_data <= 32'd0;
            exmem_rd         <= 5'd0;
            exmem_funct3     <= 3'd0;
            exmem_memRead    <= 1'b0;
            exmem_memWrite   <= 1'b0;
            exmem_regWrite   <= 1'b0;
        end else begin
            exmem_alu_result <= alu_out;
            exmem_store_data <= fwd_b;
            exmem_rd         <= rd;
            exmem_funct3     <= funct3;
            exmem_memRead    <= memRead;
            exmem_memWrite   <= memWrite;
            exmem_regWrite   <= regWrite;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: one instance with forwarding, one without,
// driven by identical inputs and compared to a behavioural model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, rs1_val, rs2_val, imm_i, imm_s;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  aluOp;
    logic        branch, memRead, memWrite, regWrite, aluSrc;
    logic [4:0]  memwb_rd;
    logic        memwb_regWrite;
    logic [31:0] memwb_value;

    logic        f_taken, f_flush, n_taken, n_flush;
    logic [31:0] f_target, n_target;
    logic [31:0] f_alu, f_store, n_alu, n_store;
    logic [4:0]  f_rd, n_rd;
    logic [2:0]  f_f3, n_f3;
    logic        f_mr, f_mw, f_rw, n_mr, n_mw, n_rw;

    typedef struct packed {
        logic [31:0] pc, rs1_val, rs2_val, imm_i, imm_s;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [1:0]  aluOp;
        logic        branch, memRead, memWrite, regWrite, aluSrc;
        logic [4:0]  memwb_rd;
        logic        memwb_regWrite;
        logic [31:0] memwb_value;
    } stim_t;

    typedef struct packed {
        logic [31:0] alu, store;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mr, mw, rw;
    } model_t;

    typedef struct packed {
        stim_t       s;
        logic [31:0] exp_alu;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    model_t mdl [2];
    int     total = 0;
    int     bad   = 0;

    always #5 clk = ~clk;

    ex_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .imm_i(imm_i), .imm_s(imm_s), .rs1(rs1), .rs2(rs2), .rd(rd),
        .funct3(funct3), .funct7(funct7), .aluOp(aluOp), .branch(branch),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .aluSrc(aluSrc),
        .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite), .memwb_value(memwb_value),
        .branch_taken(f_taken), .branch_target(f_target), .flush(f_flush),
        .exmem_alu_result(f_alu), .exmem_store_data(f_store), .exmem_rd(f_rd),
        .exmem_funct3(f_f3), .exmem_memRead(f_mr), .exmem_memWrite(f_mw),
        .exmem_regWrite(f_rw)
    );

    ex_stage #(.FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .imm_i(imm_i), .imm_s(imm_s), .rs1(rs1), .rs2(rs2), .rd(rd),
        .funct3(funct3), .funct7(funct7), .aluOp(aluOp), .branch(branch),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .aluSrc(aluSrc),
        .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite), .memwb_value(memwb_value),
        .branch_taken(n_taken), .branch_target(n_target), .flush(n_flush),
        .exmem_alu_result(n_alu), .exmem_store_data(n_store), .exmem_rd(n_rd),
        .exmem_funct3(n_f3), .exmem_memRead(n_mr), .exmem_memWrite(n_mw),
        .exmem_regWrite(n_rw)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic stim_t blank();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Register value an instruction actually sees, given the architectural
    // results still sitting in the pipeline ahead of it.
    function automatic logic [31:0] refOperand(input bit fwd, input model_t st, input stim_t s,
                                               input logic [4:0] r, input logic [31:0] v);
        if (!fwd || r == 5'd0) return v;
        if (st.rw && !st.mr && st.rd == r) return st.alu;
        if (s.memwb_regWrite && s.memwb_rd == r) return s.memwb_value;
        return v;
    endfunction

    function automatic logic [31:0] refAlu(input stim_t s, input logic [31:0] a, input logic [31:0] rb);
        logic [31:0] b;
        int          sa;
        int unsigned sh;
        b  = s.aluSrc ? s.imm_i : rb;
        sh = b % 32;
        sa = int'(a);
        case (s.aluOp)
            2'b00: return a + b;
            2'b01: return a + (~b + 32'd1);
            2'b11: return b;
            default: begin
                case (s.funct3)
                    3'd0: return (s.funct7[5] && !s.aluSrc) ? a + (~b + 32'd1) : a + b;
                    3'd1: return a << sh;
                    3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                    3'd3: return (a < b) ? 32'd1 : 32'd0;
                    3'd4: return a ^ b;
                    3'd5: return s.funct7[5] ? 32'(sa >>> sh) : (a >> sh);
                    3'd6: return a | b;
                    default: return a & b;
                endcase
            end
        endcase
    endfunction

    function automatic logic refTaken(input stim_t s, input logic [31:0] a, input logic [31:0] b);
        if (!s.branch) return 1'b0;
        case (s.funct3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) < int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] refTarget(input stim_t s);
        logic [31:0] off;
        off = {{19{s.imm_s[31]}}, s.imm_s[31], s.imm_s[0], s.imm_s[10:5], s.imm_s[4:1], 1'b0};
        return s.pc + off;
    endfunction

    task automatic applyStimulus(input stim_t s);
        pc = s.pc; rs1_val = s.rs1_val; rs2_val = s.rs2_val; imm_i = s.imm_i; imm_s = s.imm_s;
        rs1 = s.rs1; rs2 = s.rs2; rd = s.rd; funct3 = s.funct3; funct7 = s.funct7;
        aluOp = s.aluOp; branch = s.branch; memRead = s.memRead; memWrite = s.memWrite;
        regWrite = s.regWrite; aluSrc = s.aluSrc; memwb_rd = s.memwb_rd;
        memwb_regWrite = s.memwb_regWrite; memwb_value = s.memwb_value;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".alu"},    f_alu,   mdl[0].alu);
        check({tag, ".store"},  f_store, mdl[0].store);
        check({tag, ".ctl"},    {21'd0, f_rd, f_f3, f_mr, f_mw, f_rw},
              {21'd0, mdl[0].rd, mdl[0].f3, mdl[0].mr, mdl[0].mw, mdl[0].rw});
        check({tag, ".nf_alu"},   n_alu,   mdl[1].alu);
        check({tag, ".nf_store"}, n_store, mdl[1].store);
    endtask

    // One instruction through EX: comb checks mid-cycle, register checks after the edge.
    task automatic runStep(input stim_t s, input string tag);
        model_t      nxt [2];
        logic [31:0] a, b;
        logic        tk [2];
        applyStimulus(s);
        #1;
        for (int k = 0; k < 2; k++) begin
            a = refOperand(k == 0, mdl[k], s, s.rs1, s.rs1_val);
            b = refOperand(k == 0, mdl[k], s, s.rs2, s.rs2_val);
            tk[k]        = refTaken(s, a, b);
            nxt[k].alu   = refAlu(s, a, b);
            nxt[k].store = b;
            nxt[k].rd    = s.rd;
            nxt[k].f3    = s.funct3;
            nxt[k].mr    = s.memRead;
            nxt[k].mw    = s.memWrite;
            nxt[k].rw    = s.regWrite;
        end
        check({tag, ".taken"},     f_taken,  tk[0]);
        check({tag, ".flush"},     f_flush,  tk[0]);
        check({tag, ".nf_taken"},  n_taken,  tk[1]);
        check({tag, ".target"},    f_target, refTarget(s));
        check({tag, ".nf_target"}, n_target, refTarget(s));
        @(posedge clk);
        #1;
        mdl[0] = nxt[0];
        mdl[1] = nxt[1];
        checkOutput(tag);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".f_regs"}, {f_alu | f_store, 32'(f_rd), 32'(f_f3), 32'({f_mr, f_mw, f_rw})} == 128'd0, 32'd1);
        check({tag, ".n_regs"}, {n_alu | n_store, 32'(n_rd), 32'(n_f3), 32'({n_mr, n_mw, n_rw})} == 128'd0, 32'd1);
    endtask

    function automatic vec_t aluVec(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic src, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] imm, input logic [31:0] expv);
        vec_t v;
        v = '0;
        v.s.aluOp = op; v.s.funct3 = f3; v.s.funct7 = f7; v.s.aluSrc = src;
        v.s.rs1_val = a; v.s.rs2_val = b; v.s.imm_i = imm; v.s.regWrite = 1'b1; v.s.rd = 5'd9;
        v.exp_alu = expv;
        return v;
    endfunction

    function automatic vec_t brVec(input logic br, input logic [2:0] f3, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] ims,
                                   input logic tk, input logic [31:0] tgt, input logic [31:0] expv);
        vec_t v;
        v = '0;
        v.s.aluOp = 2'b01; v.s.branch = br; v.s.funct3 = f3; v.s.pc = p;
        v.s.rs1_val = a; v.s.rs2_val = b; v.s.imm_s = ims;
        v.exp_alu = expv; v.exp_taken = tk; v.exp_target = tgt;
        return v;
    endfunction

    initial begin
        vec_t  tbl[$];
        stim_t s, p, c;

        // Table vectors use x0 sources so no forwarding path is involved.
        tbl.push_back(aluVec(2'b10, 3'd5, 7'h20, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'hF8000000));
        tbl.push_back(aluVec(2'b10, 3'd5, 7'h00, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'h08000000));
        tbl.push_back(aluVec(2'b10, 3'd0, 7'h20, 1'b1, 32'd5, 32'd100, 32'd3, 32'd8));
        tbl.push_back(aluVec(2'b10, 3'd0, 7'h20, 1'b0, 32'd5, 32'd7, 32'd0, 32'hFFFFFFFE));
        tbl.push_back(aluVec(2'b10, 3'd2, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1));
        tbl.push_back(aluVec(2'b10, 3'd3, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0));
        tbl.push_back(aluVec(2'b10, 3'd1, 7'h00, 1'b0, 32'd1, 32'h25, 32'd0, 32'h20));
        tbl.push_back(aluVec(2'b10, 3'd4, 7'h00, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'hFF00FF00));
        tbl.push_back(aluVec(2'b10, 3'd6, 7'h00, 1'b0, 32'h1200, 32'h0034, 32'd0, 32'h1234));
        tbl.push_back(aluVec(2'b10, 3'd7, 7'h00, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'd0, 32'h0F000F00));
        tbl.push_back(aluVec(2'b11, 3'd0, 7'h00, 1'b1, 32'd1, 32'd2, 32'hABCD0000, 32'hABCD0000));
        tbl.push_back(aluVec(2'b00, 3'd0, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd1));
        tbl.push_back(brVec(1'b1, 3'd4, 32'h100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF1, 1'b1, 32'hF0, 32'hFFFFFFFE));
        tbl.push_back(brVec(1'b1, 3'd6, 32'h100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF1, 1'b0, 32'hF0, 32'hFFFFFFFE));
        tbl.push_back(brVec(1'b1, 3'd0, 32'h200, 32'h55, 32'h55, 32'h8, 1'b1, 32'h208, 32'd0));
        tbl.push_back(brVec(1'b1, 3'd1, 32'h200, 32'h55, 32'h55, 32'h8, 1'b0, 32'h208, 32'd0));
        tbl.push_back(brVec(1'b1, 3'd5, 32'h40, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 32'h40, 32'd2));
        tbl.push_back(brVec(1'b1, 3'd7, 32'h40, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h40, 32'd2));
        tbl.push_back(brVec(1'b1, 3'd2, 32'h40, 32'd1, 32'd2, 32'd0, 1'b0, 32'h40, 32'hFFFFFFFF));
        tbl.push_back(brVec(1'b0, 3'd0, 32'h200, 32'h55, 32'h55, 32'h8, 1'b0, 32'h208, 32'd0));

        mdl[0] = '0;
        mdl[1] = '0;

        // Reset with an ADD present: registers stay zero, even across an edge.
        s = blank();
        s.aluOp = 2'b00; s.rs1_val = 32'd3; s.rs2_val = 32'd4; s.rd = 5'd7; s.regWrite = 1'b1;
        rst = 1'b1;
        applyStimulus(s);
        #1;
        checkAllZero("reset.init");
        @(posedge clk);
        #1;
        checkAllZero("reset.edge");
        rst = 1'b0;

        runStep(s, "add");
        check("add.const", f_alu, 32'd7);

        // Mid-cycle reset clears EX/MEM without waiting for a clock edge.
        #2 rst = 1'b1;
        #1;
        checkAllZero("reset.async");
        mdl[0] = '0;
        mdl[1] = '0;
        #2 rst = 1'b0;
        runStep(s, "add.after_reset");
        check("add.after_reset.const", f_alu, 32'd7);

        $display("[TB] table vectors: %0d", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].s);
            #1;
            check($sformatf("tbl%0d.taken", i),  f_taken,  tbl[i].exp_taken);
            check($sformatf("tbl%0d.flush", i),  f_flush,  tbl[i].exp_taken);
            check($sformatf("tbl%0d.target", i), f_target, tbl[i].exp_target);
            runStep(tbl[i].s, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.alu_const", i), f_alu, tbl[i].exp_alu);
        end

        // Forwarding priority: producer writes x5=0x10, MEM/WB offers x5=0x20.
        p = blank();
        p.aluOp = 2'b11; p.aluSrc = 1'b1; p.imm_i = 32'h10; p.rd = 5'd5; p.regWrite = 1'b1;
        c = blank();
        c.aluOp = 2'b00; c.rs1 = 5'd5; c.rs1_val = 32'h1; c.rs2_val = 32'h100;
        c.memwb_rd = 5'd5; c.memwb_regWrite = 1'b1; c.memwb_value = 32'h20;
        runStep(p, "fwd.prod");
        runStep(c, "fwd.ex");
        check("fwd.ex_prio", f_alu, 32'h110);
        check("nofwd.ex_prio", n_alu, 32'h101);

        p.memRead = 1'b1;
        runStep(p, "fwd.prod_load");
        runStep(c, "fwd.wb");
        check("fwd.load_skips_exmem", f_alu, 32'h120);
        check("nofwd.load", n_alu, 32'h101);

        p.memRead = 1'b0; p.rd = 5'd0;
        c.rs1 = 5'd0; c.memwb_rd = 5'd0;
        runStep(p, "fwd.prod_x0");
        runStep(c, "fwd.x0");
        check("fwd.x0_never", f_alu, 32'h101);

        p.rd = 5'd5;
        c.rs1 = 5'd5; c.rs2 = 5'd5; c.memwb_rd = 5'd5;
        runStep(p, "fwd.prod_both");
        runStep(c, "fwd.both");
        check("fwd.both_alu", f_alu, 32'h20);
        check("fwd.both_store", f_store, 32'h10);
        check("nofwd.both_alu", n_alu, 32'h101);
        check("nofwd.both_store", n_store, 32'h100);

        // Store with data forwarded from MEM/WB.
        runStep(blank(), "bubble");
        s = blank();
        s.aluOp = 2'b00; s.aluSrc = 1'b1; s.imm_i = 32'd8; s.rs1 = 5'd2; s.rs1_val = 32'h1000;
        s.rs2 = 5'd3; s.rs2_val = 32'h1; s.memWrite = 1'b1; s.funct3 = 3'b010;
        s.memwb_rd = 5'd3; s.memwb_regWrite = 1'b1; s.memwb_value = 32'hDEADBEEF;
        runStep(s, "sw");
        check("sw.addr", f_alu, 32'h1008);
        check("sw.data", f_store, 32'hDEADBEEF);
        check("sw.memWrite", f_mw, 1'b1);
        check("nofwd.sw.data", n_store, 32'h1);

        // Random traffic with a narrow register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            s = blank();
            s.pc = $urandom & 32'hFFFFFFFC;
            s.rs1_val = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            s.rs2_val = ($urandom_range(0, 3) == 0) ? s.rs1_val : $urandom;
            s.imm_i = $urandom; s.imm_s = $urandom;
            s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
            s.rd = 5'($urandom_range(0, 3));
            s.funct3 = 3'($urandom); s.aluOp = 2'($urandom);
            s.funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            s.branch = 1'($urandom); s.memRead = ($urandom_range(0, 3) == 0);
            s.memWrite = 1'($urandom); s.regWrite = 1'($urandom); s.aluSrc = 1'($urandom);
            s.memwb_rd = 5'($urandom_range(0, 3)); s.memwb_regWrite = 1'($urandom);
            s.memwb_value = $urandom;
            runStep(s, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
